// File: rtl/spike_writeback_packer_if.sv
// Spike-stream and memory-write signals of the writeback packer.
// The packer takes the slave view; the producer/memory environment takes the master view.
interface spike_writeback_packer_if #(
    parameter int NUM_PES = 9,
    parameter int WORD_W  = 32,
    parameter int ADDR_W  = 10
);
    logic               spk_valid;
    logic [NUM_PES-1:0] spk_data;
    logic               spk_ready;
    logic               mem_wvalid;
    logic               mem_wready;
    logic [ADDR_W-1:0]  mem_addr;
    logic [WORD_W-1:0]  mem_wdata;

    modport slave (
        input  spk_valid, spk_data, mem_wready,
        output spk_ready, mem_wvalid, mem_addr, mem_wdata
    );

    modport master (
        output spk_valid, spk_data, mem_wready,
        input  spk_ready, mem_wvalid, mem_addr, mem_wdata
    );
endinterface

// File: rtl/spike_writeback_packer.sv
// Packs NUM_PES-bit spike vectors LSB-first into WORD_W-bit words, buffers them
// in a small FIFO and writes them to the output spike SRAM at incrementing addresses.
module spike_writeback_packer #(
    parameter int NUM_PES    = 9,
    parameter int WORD_W     = 32,
    parameter int FIFO_DEPTH = 4,
    parameter int ADDR_W     = 10
) (
    input  logic                    clk,
    input  logic                    nrst,
    input  logic                    start,
    input  logic [ADDR_W-1:0]       base_addr,
    input  logic [3:0]              c_out,
    input  logic [3:0]              num_timesteps,
    spike_writeback_packer_if.slave bus,
    output logic                    busy,
    output logic                    done
);
    localparam int CNT_W  = $clog2(WORD_W) + 1;
    localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int FCNT_W = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RUN,
        S_FLUSH,
        S_DRAIN,
        S_DONE
    } state_e;

    state_e              state_q, state_d;
    logic [7:0]          total_q, total_d;
    logic [7:0]          vec_cnt_q, vec_cnt_d;
    logic [WORD_W-1:0]   pack_q, pack_d;
    logic [CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [WORD_W-1:0]   fifo_mem_q [FIFO_DEPTH];
    logic [WORD_W-1:0]   fifo_mem_d [FIFO_DEPTH];
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [FCNT_W-1:0]   fifo_cnt_q, fifo_cnt_d;
    logic                spk_ready_q, spk_ready_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;

    logic [2*WORD_W-1:0] merged;
    logic [CNT_W-1:0]    bit_sum;
    logic [7:0]          job_total;
    logic                accept;
    logic                push;
    logic                pop;
    logic [WORD_W-1:0]   push_data;

    // NOTE: every variable written here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d    = state_q;
        total_d    = total_q;
        vec_cnt_d  = vec_cnt_q;
        pack_d     = pack_q;
        bit_cnt_d  = bit_cnt_q;
        addr_d     = addr_q;
        fifo_mem_d = fifo_mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        fifo_cnt_d = fifo_cnt_q;
        push       = 1'b0;
        push_data  = '0;

        merged    = {{WORD_W{1'b0}}, pack_q}
                  | ({{(2*WORD_W-NUM_PES){1'b0}}, bus.spk_data} << bit_cnt_q);
        bit_sum   = bit_cnt_q + CNT_W'(NUM_PES);
        job_total = {4'b0, c_out} * {4'b0, num_timesteps};
        accept    = bus.spk_valid && spk_ready_q;
        pop       = (fifo_cnt_q != '0) && bus.mem_wready;

        if (pop) begin
            addr_d = addr_q + 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    total_d   = job_total;
                    addr_d    = base_addr;
                    vec_cnt_d = '0;
                    pack_d    = '0;
                    bit_cnt_d = '0;
                    state_d   = (job_total == 8'd0) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                if (accept) begin
                    vec_cnt_d = vec_cnt_q + 8'd1;
                    if (bit_sum >= CNT_W'(WORD_W)) begin
                        push      = 1'b1;
                        push_data = merged[WORD_W-1:0];
                        pack_d    = merged[2*WORD_W-1:WORD_W];
                        bit_cnt_d = bit_sum - CNT_W'(WORD_W);
                    end else begin
                        pack_d    = merged[WORD_W-1:0];
                        bit_cnt_d = bit_sum;
                    end
                    if (vec_cnt_d == total_q) begin
                        state_d = (bit_cnt_d != '0) ? S_FLUSH : S_DRAIN;
                    end
                end
            end
            S_FLUSH: begin
                // Bits above bit_cnt are already zero, so the residual needs no masking.
                if (fifo_cnt_q < FCNT_W'(FIFO_DEPTH)) begin
                    push      = 1'b1;
                    push_data = pack_q;
                    pack_d    = '0;
                    bit_cnt_d = '0;
                    state_d   = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (fifo_cnt_q == '0) begin
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        if (push) begin
            fifo_mem_d[wr_ptr_q] = push_data;
            wr_ptr_d = (wr_ptr_q == PTR_W'(FIFO_DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == PTR_W'(FIFO_DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
        end
        if (push && !pop) begin
            fifo_cnt_d = fifo_cnt_q + 1'b1;
        end else if (!push && pop) begin
            fifo_cnt_d = fifo_cnt_q - 1'b1;
        end

        spk_ready_d = (state_d == S_RUN) && (fifo_cnt_d < FCNT_W'(FIFO_DEPTH));
        busy_d      = (state_d != S_IDLE);
        done_d      = (state_d == S_DONE);
    end

    // NOTE: sequential state uses non-blocking assignments only, so all flops update together.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q     <= S_IDLE;
            total_q     <= '0;
            vec_cnt_q   <= '0;
            pack_q      <= '0;
            bit_cnt_q   <= '0;
            addr_q      <= '0;
            // NOTE: the FIFO storage is reset because its head drives mem_wdata, which must read 0 in reset.
            fifo_mem_q  <= '{default: '0};
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            fifo_cnt_q  <= '0;
            spk_ready_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            total_q     <= total_d;
            vec_cnt_q   <= vec_cnt_d;
            pack_q      <= pack_d;
            bit_cnt_q   <= bit_cnt_d;
            addr_q      <= addr_d;
            fifo_mem_q  <= fifo_mem_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            fifo_cnt_q  <= fifo_cnt_d;
            spk_ready_q <= spk_ready_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign bus.spk_ready  = spk_ready_q;
    assign bus.mem_wvalid = (fifo_cnt_q != '0);
    assign bus.mem_addr   = addr_q;
    assign bus.mem_wdata  = fifo_mem_q[rd_ptr_q];
    assign busy           = busy_q;
    assign done           = done_q;
endmodule

// File: tb/tb_spike_writeback_packer.sv
// Directed self-checking bench for spike_writeback_packer: one task per scenario,
// memory writes and done pulses captured by a monitor on each rising edge.
module tb_spike_writeback_packer;
    logic       clk;
    logic       nrst;
    logic       start;
    logic [9:0] base_addr;
    logic [3:0] c_out;
    logic [3:0] num_timesteps;
    logic       busy;
    logic       done;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [9:0]  wr_addr_q [$];
    logic [31:0] wr_data_q [$];
    int          done_cnt = 0;

    spike_writeback_packer_if #(.NUM_PES(9), .WORD_W(32), .ADDR_W(10)) bus ();

    spike_writeback_packer #(
        .NUM_PES(9), .WORD_W(32), .FIFO_DEPTH(4), .ADDR_W(10)
    ) dut (
        .clk           (clk),
        .nrst          (nrst),
        .start         (start),
        .base_addr     (base_addr),
        .c_out         (c_out),
        .num_timesteps (num_timesteps),
        .bus           (bus),
        .busy          (busy),
        .done          (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (nrst && bus.mem_wvalid && bus.mem_wready) begin
            wr_addr_q.push_back(bus.mem_addr);
            wr_data_q.push_back(bus.mem_wdata);
        end
        if (nrst && done) done_cnt++;
    end

    function automatic logic [9:0] got_addr(input int k);
        return (wr_addr_q.size() > k) ? wr_addr_q[k] : 10'bx;
    endfunction

    function automatic logic [31:0] got_data(input int k);
        return (wr_data_q.size() > k) ? wr_data_q[k] : 32'bx;
    endfunction

    task automatic clear_log();
        wr_addr_q.delete();
        wr_data_q.delete();
    endtask

    task automatic start_job(input logic [9:0] b, input logic [3:0] c, input logic [3:0] t);
        base_addr     = b;
        c_out         = c;
        num_timesteps = t;
        start         = 1'b1;
        @(negedge clk);
        start         = 1'b0;
    endtask

    task automatic send_vec(input logic [8:0] v);
        bit ok = 1'b0;
        bus.spk_valid = 1'b1;
        bus.spk_data  = v;
        for (int i = 0; i < 200; i++) begin
            if (bus.spk_ready) begin
                @(negedge clk);
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) begin
            tests_run++; tests_failed++;
            $display("FAIL send_vec timeout: vector %h not accepted within 200 cycles", v);
        end
    endtask

    task automatic wait_done(input int max_cycles);
        int  n0 = done_cnt;
        bit  ok = 1'b0;
        for (int i = 0; i < max_cycles; i++) begin
            @(negedge clk);
            if (done_cnt != n0) begin ok = 1'b1; break; end
        end
        if (!ok) begin
            tests_run++; tests_failed++;
            $display("FAIL wait_done timeout: no done pulse within %0d cycles", max_cycles);
        end
    endtask

    task automatic test_reset();
        nrst = 1'b0; start = 1'b0; base_addr = '0; c_out = '0; num_timesteps = '0;
        bus.spk_valid = 1'b0; bus.spk_data = '0; bus.mem_wready = 1'b0;
        repeat (2) @(negedge clk);
        tests_run++;
        if ({bus.spk_ready, bus.mem_wvalid, busy, done} !== 4'b0) begin
            tests_failed++;
            $display("FAIL reset_ctrl: got %b required 0000", {bus.spk_ready, bus.mem_wvalid, busy, done});
        end
        tests_run++;
        if ({bus.mem_addr, bus.mem_wdata} !== 42'b0) begin
            tests_failed++;
            $display("FAIL reset_bus: addr %h data %h required 0", bus.mem_addr, bus.mem_wdata);
        end
        nrst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic_packing();
        int d0;
        bus.mem_wready = 1'b1;
        clear_log();
        d0 = done_cnt;
        start_job(10'h010, 4'd2, 4'd2);
        for (int i = 0; i < 4; i++) send_vec(9'h1FF);
        bus.spk_valid = 1'b0;
        wait_done(50);
        repeat (3) @(negedge clk);
        tests_run++;
        if (wr_addr_q.size() !== 2) begin
            tests_failed++; $display("FAIL basic_count: got %0d writes required 2", wr_addr_q.size());
        end
        tests_run++;
        if (got_addr(0) !== 10'h010 || got_data(0) !== 32'hFFFF_FFFF) begin
            tests_failed++; $display("FAIL basic_w0: got %h/%h required 010/ffffffff", got_addr(0), got_data(0));
        end
        tests_run++;
        if (got_addr(1) !== 10'h011 || got_data(1) !== 32'h0000_000F) begin
            tests_failed++; $display("FAIL basic_w1: got %h/%h required 011/0000000f", got_addr(1), got_data(1));
        end
        tests_run++;
        if (done_cnt - d0 !== 1) begin
            tests_failed++; $display("FAIL basic_done_pulses: got %0d required 1", done_cnt - d0);
        end
        tests_run++;
        if (busy !== 1'b0) begin
            tests_failed++; $display("FAIL basic_busy_after: got %b required 0", busy);
        end
    endtask

    task automatic test_bit_order();
        logic [8:0] vecs [4];
        vecs[0] = 9'h001; vecs[1] = 9'h002; vecs[2] = 9'h004; vecs[3] = 9'h100;
        bus.mem_wready = 1'b1;
        clear_log();
        start_job(10'h040, 4'd1, 4'd4);
        for (int i = 0; i < 4; i++) send_vec(vecs[i]);
        bus.spk_valid = 1'b0;
        wait_done(50);
        tests_run++;
        if (wr_addr_q.size() !== 2) begin
            tests_failed++; $display("FAIL order_count: got %0d writes required 2", wr_addr_q.size());
        end
        // Offsets 0, 9, 18, 27: bits 0, 10, 20 in word0; bit 35 lands in word1 bit 3.
        tests_run++;
        if (got_addr(0) !== 10'h040 || got_data(0) !== 32'h0010_0401) begin
            tests_failed++; $display("FAIL order_w0: got %h/%h required 040/00100401", got_addr(0), got_data(0));
        end
        tests_run++;
        if (got_addr(1) !== 10'h041 || got_data(1) !== 32'h0000_0008) begin
            tests_failed++; $display("FAIL order_w1: got %h/%h required 041/00000008", got_addr(1), got_data(1));
        end
    endtask

    task automatic test_backpressure();
        logic [191:0] stream = '0;
        logic [8:0]   v;
        bus.mem_wready = 1'b0;
        clear_log();
        start_job(10'h020, 4'd15, 4'd1);
        for (int i = 0; i < 15; i++) begin
            v = 9'((i + 1) * 37);
            stream = stream | (192'(v) << (9 * i));
            send_vec(v);
        end
        tests_run++;
        if (bus.spk_ready !== 1'b0) begin
            tests_failed++; $display("FAIL bp_ready_low: got %b required 0", bus.spk_ready);
        end
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            tests_run++;
            if (bus.mem_wvalid !== 1'b1 || bus.mem_addr !== 10'h020 || bus.mem_wdata !== stream[31:0]) begin
                tests_failed++;
                $display("FAIL bp_stall_hold: cycle %0d got v=%b %h/%h required 1 020/%h",
                         c, bus.mem_wvalid, bus.mem_addr, bus.mem_wdata, stream[31:0]);
            end
        end
        bus.spk_valid  = 1'b0;
        bus.mem_wready = 1'b1;
        wait_done(50);
        tests_run++;
        if (wr_addr_q.size() !== 5) begin
            tests_failed++; $display("FAIL bp_count: got %0d writes required 5", wr_addr_q.size());
        end
        for (int k = 0; k < 5; k++) begin
            tests_run++;
            if (got_addr(k) !== 10'(10'h020 + k) || got_data(k) !== stream[32*k +: 32]) begin
                tests_failed++;
                $display("FAIL bp_word%0d: got %h/%h required %h/%h",
                         k, got_addr(k), got_data(k), 10'(10'h020 + k), stream[32*k +: 32]);
            end
        end
    endtask

    task automatic test_zero_job();
        bus.mem_wready = 1'b1;
        clear_log();
        start_job(10'h100, 4'd0, 4'd5);
        tests_run++;
        if (done !== 1'b1 || bus.spk_ready !== 1'b0) begin
            tests_failed++; $display("FAIL zero_done_high: got done=%b ready=%b required 1 0", done, bus.spk_ready);
        end
        @(negedge clk);
        tests_run++;
        if (done !== 1'b0 || busy !== 1'b0 || bus.spk_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL zero_after: got done=%b busy=%b ready=%b required 0 0 0", done, busy, bus.spk_ready);
        end
        repeat (3) @(negedge clk);
        tests_run++;
        if (wr_addr_q.size() !== 0) begin
            tests_failed++; $display("FAIL zero_writes: got %0d writes required 0", wr_addr_q.size());
        end
    endtask

    task automatic test_addr_wrap();
        logic [9:0]  exp_a [3];
        logic [31:0] exp_d [3];
        exp_a[0] = 10'h3FF; exp_a[1] = 10'h000; exp_a[2] = 10'h001;
        exp_d[0] = 32'hFFFF_FFFF; exp_d[1] = 32'hFFFF_FFFF; exp_d[2] = 32'h0000_00FF;
        bus.mem_wready = 1'b1;
        clear_log();
        start_job(10'h3FF, 4'd8, 4'd1);
        for (int i = 0; i < 8; i++) send_vec(9'h1FF);
        bus.spk_valid = 1'b0;
        wait_done(50);
        tests_run++;
        if (wr_addr_q.size() !== 3) begin
            tests_failed++; $display("FAIL wrap_count: got %0d writes required 3", wr_addr_q.size());
        end
        for (int k = 0; k < 3; k++) begin
            tests_run++;
            if (got_addr(k) !== exp_a[k] || got_data(k) !== exp_d[k]) begin
                tests_failed++;
                $display("FAIL wrap_word%0d: got %h/%h required %h/%h", k, got_addr(k), got_data(k), exp_a[k], exp_d[k]);
            end
        end
    endtask

    task automatic test_reset_mid_job();
        bus.mem_wready = 1'b0;
        clear_log();
        start_job(10'h123, 4'd15, 4'd1);
        for (int i = 0; i < 8; i++) send_vec(9'h1FF);
        bus.spk_valid = 1'b0;
        tests_run++;
        if (bus.mem_wvalid !== 1'b1 || busy !== 1'b1) begin
            tests_failed++; $display("FAIL midrst_pre: got wvalid=%b busy=%b required 1 1", bus.mem_wvalid, busy);
        end
        #2 nrst = 1'b0;
        #1;
        tests_run++;
        if ({bus.mem_wvalid, bus.spk_ready, busy, done} !== 4'b0 || bus.mem_addr !== 10'h0
            || bus.mem_wdata !== 32'h0) begin
            tests_failed++;
            $display("FAIL midrst_outputs: got ctrl=%b addr=%h data=%h required 0000 000 00000000",
                     {bus.mem_wvalid, bus.spk_ready, busy, done}, bus.mem_addr, bus.mem_wdata);
        end
        @(negedge clk);
        nrst = 1'b1;
        @(negedge clk);
        bus.mem_wready = 1'b1;
        clear_log();
        start_job(10'h050, 4'd1, 4'd1);
        send_vec(9'h0AA);
        bus.spk_valid = 1'b0;
        wait_done(50);
        tests_run++;
        if (wr_addr_q.size() !== 1 || got_addr(0) !== 10'h050 || got_data(0) !== 32'h0000_00AA) begin
            tests_failed++;
            $display("FAIL midrst_new_job: got %0d writes %h/%h required 1 050/000000aa",
                     wr_addr_q.size(), got_addr(0), got_data(0));
        end
    endtask

    initial begin
        test_reset();
        test_basic_packing();
        test_bit_order();
        test_backpressure();
        test_zero_job();
        test_addr_wrap();
        test_reset_mid_job();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end
endmodule
